// File: rtl/seg_page_ctrl.sv
// Display-content scheduler: rotates two live pages on a dwell timer and lets a
// latched, blinking alert pre-empt them. All outputs are registered from next-state values.
module seg_page_ctrl #(
  parameter int unsigned CW         = 32,
  parameter int unsigned DWELL      = 100000000,
  parameter int unsigned ALERT_HOLD = 300000000,
  parameter int unsigned BLINK      = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rotate_en,
  input  logic        next_btn,
  input  logic [15:0] src0_data,
  input  logic [3:0]  src0_dp,
  input  logic [15:0] src1_data,
  input  logic [3:0]  src1_dp,
  input  logic        alert_req,
  input  logic [15:0] alert_data,
  input  logic [3:0]  alert_dp,
  output logic [3:0]  hex0,
  output logic [3:0]  hex1,
  output logic [3:0]  hex2,
  output logic [3:0]  hex3,
  output logic [3:0]  dp_out,
  output logic        blank,
  output logic [1:0]  page,
  output logic        alert_done
);
  typedef enum logic [1:0] {SHOW0 = 2'd0, SHOW1 = 2'd1, ALERT = 2'd2} state_t;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(ALERT_HOLD - 1);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK - 1);
  localparam logic [CW-1:0] ONE        = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] alert_cnt_q, alert_cnt_d;
  logic [CW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic          ret_q, ret_d;
  logic [15:0]   adata_q, adata_d;
  logic [3:0]    adp_q, adp_d;
  logic          done_d;
  logic [15:0]   disp_q, disp_d;
  logic [3:0]    dp_q, dp_d;
  logic          blank_q, blank_d;
  logic [1:0]    page_q, page_d;
  logic          done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SHOW0;
      dwell_q     <= '0;
      alert_cnt_q <= '0;
      blink_q     <= '0;
      phase_q     <= 1'b0;
      ret_q       <= 1'b0;
      adata_q     <= '0;
      adp_q       <= '0;
      disp_q      <= '0;
      dp_q        <= '0;
      blank_q     <= 1'b0;
      page_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      alert_cnt_q <= alert_cnt_d;
      blink_q     <= blink_d;
      phase_q     <= phase_d;
      ret_q       <= ret_d;
      adata_q     <= adata_d;
      adp_q       <= adp_d;
      disp_q      <= disp_d;
      dp_q        <= dp_d;
      blank_q     <= blank_d;
      page_q      <= page_d;
      done_q      <= done_d;
    end
  end

  // blink_cnt/phase track (alert_cnt / BLINK) parity without a divider
  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    alert_cnt_d = alert_cnt_q;
    blink_d     = blink_q;
    phase_d     = phase_q;
    ret_d       = ret_q;
    adata_d     = adata_q;
    adp_d       = adp_q;
    done_d      = 1'b0;
    case (state_q)
      SHOW0, SHOW1: begin
        if (alert_req) begin
          adata_d     = alert_data;
          adp_d       = alert_dp;
          ret_d       = (state_q == SHOW1);
          state_d     = ALERT;
          alert_cnt_d = '0;
          blink_d     = '0;
          phase_d     = 1'b0;
          dwell_d     = '0;
        end else if (next_btn) begin
          state_d = (state_q == SHOW0) ? SHOW1 : SHOW0;
          dwell_d = '0;
        end else if (rotate_en) begin
          if (dwell_q == DWELL_LAST) begin
            state_d = (state_q == SHOW0) ? SHOW1 : SHOW0;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + ONE;
          end
        end else begin
          dwell_d = '0;
        end
      end
      ALERT: begin
        dwell_d = '0;
        if (alert_req) begin
          adata_d     = alert_data;
          adp_d       = alert_dp;
          alert_cnt_d = '0;
          blink_d     = '0;
          phase_d     = 1'b0;
        end else if (next_btn || alert_cnt_q == HOLD_LAST) begin
          state_d     = ret_q ? SHOW1 : SHOW0;
          done_d      = 1'b1;
          alert_cnt_d = '0;
          blink_d     = '0;
          phase_d     = 1'b0;
        end else begin
          alert_cnt_d = alert_cnt_q + ONE;
          if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            phase_d = ~phase_q;
          end else begin
            blink_d = blink_q + ONE;
          end
        end
      end
      default: state_d = SHOW0;
    endcase
  end

  always_comb begin
    disp_d  = src0_data;
    dp_d    = src0_dp;
    blank_d = 1'b0;
    page_d  = state_d;
    case (state_d)
      SHOW1: begin
        disp_d = src1_data;
        dp_d   = src1_dp;
      end
      ALERT: begin
        disp_d  = adata_d;
        dp_d    = adp_d;
        blank_d = phase_d;
      end
      default: ;
    endcase
  end

  assign hex0       = disp_q[3:0];
  assign hex1       = disp_q[7:4];
  assign hex2       = disp_q[11:8];
  assign hex3       = disp_q[15:12];
  assign dp_out     = dp_q;
  assign blank      = blank_q;
  assign page       = page_q;
  assign alert_done = done_q;
endmodule

// File: tb/tb_seg_page_ctrl.sv
// Bench for seg_page_ctrl: directed vector table, reset corner cases and a
// randomized run, all checked against a rule-level reference model.
module tb_seg_page_ctrl;
  localparam int DW = 8;
  localparam int AH = 12;
  localparam int BL = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rotate_en = 1'b0, next_btn = 1'b0, alert_req = 1'b0;
  logic [15:0] s0 = 16'h2022, s1 = 16'h0118, alert_data = '0;
  logic [3:0]  s0dp = 4'b0001, s1dp = 4'b1000, alert_dp = '0;
  logic [3:0]  hex0, hex1, hex2, hex3, dp_out;
  logic        blank, alert_done;
  logic [1:0]  page;

  seg_page_ctrl #(.CW(32), .DWELL(DW), .ALERT_HOLD(AH), .BLINK(BL)) dut (
    .clk(clk), .rst_n(rst_n), .rotate_en(rotate_en), .next_btn(next_btn),
    .src0_data(s0), .src0_dp(s0dp), .src1_data(s1), .src1_dp(s1dp),
    .alert_req(alert_req), .alert_data(alert_data), .alert_dp(alert_dp),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .dp_out(dp_out),
    .blank(blank), .page(page), .alert_done(alert_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: page number, dwell/alert ages, saved return page
  int          m_pg, m_dwell, m_acnt, m_ret;
  logic [15:0] m_ad;
  logic [3:0]  m_adp;
  bit          m_done;

  task automatic model_reset();
    m_pg = 0; m_dwell = 0; m_acnt = 0; m_ret = 0; m_ad = '0; m_adp = '0; m_done = 0;
  endtask

  task automatic model_step(input bit rot, btn, req, input logic [15:0] ad, input logic [3:0] adp);
    m_done = 0;
    if (m_pg != 2) begin
      if (req) begin
        m_ad = ad; m_adp = adp; m_ret = m_pg; m_pg = 2; m_acnt = 0; m_dwell = 0;
      end else if (btn) begin
        m_pg = 1 - m_pg; m_dwell = 0;
      end else if (rot) begin
        if (m_dwell == DW - 1) begin m_pg = 1 - m_pg; m_dwell = 0; end
        else m_dwell++;
      end else m_dwell = 0;
    end else begin
      if (req) begin
        m_ad = ad; m_adp = adp; m_acnt = 0;
      end else if (btn || m_acnt == AH - 1) begin
        m_pg = m_ret; m_done = 1; m_acnt = 0;
      end else m_acnt++;
    end
  endtask

  task automatic model_check();
    logic [15:0] eh;
    logic [3:0]  ed;
    eh = (m_pg == 0) ? s0 : (m_pg == 1) ? s1 : m_ad;
    ed = (m_pg == 0) ? s0dp : (m_pg == 1) ? s1dp : m_adp;
    cmp("model_page", 32'(page), 32'(m_pg));
    cmp("model_hex", {16'h0, hex3, hex2, hex1, hex0}, {16'h0, eh});
    cmp("model_dp", 32'(dp_out), 32'(ed));
    cmp("model_blank", 32'(blank), 32'((m_pg == 2) && ((m_acnt / BL) % 2 == 1)));
    cmp("model_done", 32'(alert_done), 32'(m_done));
  endtask

  task automatic step(input bit rot, btn, req, input logic [15:0] ad, input logic [3:0] adp);
    @(negedge clk);
    rotate_en = rot; next_btn = btn; alert_req = req; alert_data = ad; alert_dp = adp;
    @(posedge clk);
    model_step(rot, btn, req, ad, adp);
    #1;
    model_check();
  endtask

  typedef struct {
    bit rot, btn, req;
    logic [15:0] ad;
    logic [3:0]  adp;
    logic [1:0]  pg;
    bit blk, done;
    logic [15:0] hx;
    logic [3:0]  dp;
  } vec_t;
  vec_t vecs[$];

  task automatic addp(input bit rot, btn, input logic [1:0] pg, input bit done);
    vec_t v;
    v.rot = rot; v.btn = btn; v.req = 0; v.ad = '0; v.adp = '0; v.pg = pg;
    v.blk = 0; v.done = done;
    v.hx = (pg == 2'd1) ? 16'h0118 : 16'h2022;
    v.dp = (pg == 2'd1) ? 4'b1000 : 4'b0001;
    vecs.push_back(v);
  endtask

  task automatic adda(input bit rot, btn, req, input logic [15:0] ad, input logic [3:0] adp,
                      input bit blk, input logic [15:0] hx, input logic [3:0] dp);
    vec_t v;
    v.rot = rot; v.btn = btn; v.req = req; v.ad = ad; v.adp = adp; v.pg = 2'd2;
    v.blk = blk; v.done = 0; v.hx = hx; v.dp = dp;
    vecs.push_back(v);
  endtask

  task automatic out_zero(input string tag);
    cmp({tag, "_hex"}, {16'h0, hex3, hex2, hex1, hex0}, 32'h0);
    cmp({tag, "_dp"}, 32'(dp_out), 32'h0);
    cmp({tag, "_blank"}, 32'(blank), 32'h0);
    cmp({tag, "_page"}, 32'(page), 32'h0);
    cmp({tag, "_done"}, 32'(alert_done), 32'h0);
  endtask

  initial begin
    logic [11:0] bpat;
    bpat = 12'hE38;  // blank per alert age 0..11

    // Table: rotation, freeze, button, button+expiry, alert timeout/retrigger/dismiss
    for (int i = 0; i < 7; i++) addp(1, 0, 0, 0);
    addp(1, 0, 1, 0);
    for (int i = 0; i < 7; i++) addp(1, 0, 1, 0);
    addp(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) addp(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) addp(0, 0, 0, 0);
    addp(0, 1, 1, 0);
    for (int i = 0; i < 7; i++) addp(1, 0, 1, 0);
    addp(1, 1, 0, 0);
    addp(1, 0, 0, 0);
    addp(0, 1, 1, 0);
    adda(0, 0, 1, 16'hA1E7, 4'b0101, bpat[0], 16'hA1E7, 4'b0101);
    for (int i = 1; i < 12; i++) adda(1, 0, 0, 16'h0, 4'h0, bpat[i], 16'hA1E7, 4'b0101);
    addp(1, 0, 1, 1);
    addp(0, 0, 1, 0);
    adda(0, 0, 1, 16'hBEEF, 4'hF, 0, 16'hBEEF, 4'hF);
    for (int i = 1; i < 6; i++) adda(0, 0, 0, 16'h0, 4'h0, bpat[i], 16'hBEEF, 4'hF);
    adda(0, 0, 1, 16'hC0DE, 4'h2, 0, 16'hC0DE, 4'h2);
    for (int i = 1; i < 12; i++) adda(0, 0, 0, 16'h0, 4'h0, bpat[i], 16'hC0DE, 4'h2);
    addp(0, 0, 1, 1);
    addp(0, 0, 1, 0);
    adda(0, 0, 1, 16'h1234, 4'h0, 0, 16'h1234, 4'h0);
    adda(0, 0, 0, 16'h0, 4'h0, 0, 16'h1234, 4'h0);
    addp(0, 1, 1, 1);
    addp(0, 0, 1, 0);
    adda(0, 0, 1, 16'h5555, 4'h3, 0, 16'h5555, 4'h3);
    adda(0, 0, 0, 16'h0, 4'h0, 0, 16'h5555, 4'h3);
    adda(0, 0, 0, 16'h0, 4'h0, 0, 16'h5555, 4'h3);
    adda(0, 1, 1, 16'h6666, 4'h4, 0, 16'h6666, 4'h4);
    adda(0, 0, 0, 16'h0, 4'h0, 0, 16'h6666, 4'h4);
    addp(0, 1, 1, 1);
    adda(0, 0, 1, 16'h7777, 4'h5, 0, 16'h7777, 4'h5);
    for (int i = 1; i < 12; i++) adda(0, 0, 0, 16'h0, 4'h0, bpat[i], 16'h7777, 4'h5);
    adda(0, 0, 1, 16'h8888, 4'h6, 0, 16'h8888, 4'h6);
    adda(0, 0, 0, 16'h0, 4'h0, 0, 16'h8888, 4'h6);
    addp(0, 1, 1, 1);

    // Reset hold
    model_reset();
    repeat (10) @(posedge clk);
    #1 out_zero("in_reset");
    repeat (10) @(posedge clk);
    #1 out_zero("in_reset_late");
    @(negedge clk) rst_n = 1'b1;
    step(0, 0, 0, 16'h0, 4'h0);
    cmp("first_hex", {16'h0, hex3, hex2, hex1, hex0}, 32'h2022);
    cmp("first_page", 32'(page), 32'h0);

    foreach (vecs[k]) begin
      step(vecs[k].rot, vecs[k].btn, vecs[k].req, vecs[k].ad, vecs[k].adp);
      cmp($sformatf("vec%0d_page", k), 32'(page), 32'(vecs[k].pg));
      cmp($sformatf("vec%0d_blank", k), 32'(blank), 32'(vecs[k].blk));
      cmp($sformatf("vec%0d_done", k), 32'(alert_done), 32'(vecs[k].done));
      cmp($sformatf("vec%0d_hex", k), {16'h0, hex3, hex2, hex1, hex0}, {16'h0, vecs[k].hx});
      cmp($sformatf("vec%0d_dp", k), 32'(dp_out), 32'(vecs[k].dp));
    end

    // Reset mid-alert (alert age 4, inside a blank window)
    step(0, 0, 1, 16'h9ABC, 4'h9);
    repeat (4) step(0, 0, 0, 16'h0, 4'h0);
    cmp("pre_rst_blank", 32'(blank), 32'h1);
    #2 rst_n = 1'b0;
    #1 out_zero("mid_alert_rst");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 16'h0, 4'h0);
    cmp("post_rst_page", 32'(page), 32'h0);
    cmp("post_rst_done", 32'(alert_done), 32'h0);
    repeat (3) step(0, 0, 0, 16'h0, 4'h0);
    cmp("post_rst_done_late", 32'(alert_done), 32'h0);

    // Randomized run against the model, live sources changing
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) begin
        s0 = 16'($urandom); s0dp = 4'($urandom);
        s1 = 16'($urandom); s1dp = 4'($urandom);
      end
      step($urandom_range(3) != 0, $urandom_range(11) == 0, $urandom_range(19) == 0,
           16'($urandom), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule

// File: doc/seg_page_ctrl.md
Name: seg_page_ctrl

Overview:
- Display-content scheduler in front of one 4-digit `seg_display` multiplexer.
- Shares the display between two live "pages" (e.g. a year/date word and a time word) and a one-shot alert message.
- Auto-rotates pages on a dwell timer; a user button advances the page. An alert pre-empts both pages for a fixed hold time, with blinking.
- Drives `seg_display` hex0..hex3 and dp_in directly; `blank` gates the anodes downstream.

Parameters:
- CW, 32, width of all internal counters.
- DWELL, 100000000, cycles each page is shown while rotating (1 s at 100 MHz); legal range 2..2^CW-1.
- ALERT_HOLD, 300000000, cycles an alert is shown; legal range 2..2^CW-1.
- BLINK, 25000000, half-period of alert blink in cycles; must satisfy 1 <= BLINK < ALERT_HOLD.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rotate_en  in  1  1 = auto-rotate pages on dwell timer.
- next_btn  in  1  single-cycle pulse (already debounced): advance page, or dismiss an active alert.
- src0_data  in  16  page 0 digits; [3:0] maps to hex0 … [15:12] maps to hex3.
- src0_dp  in  4  page 0 decimal points.
- src1_data  in  16  page 1 digits.
- src1_dp  in  4  page 1 decimal points.
- alert_req  in  1  single-cycle pulse: show the alert.
- alert_data  in  16  alert digits, sampled only when alert_req=1.
- alert_dp  in  4  alert decimal points, sampled only when alert_req=1.
- hex0..hex3  out  4 each  digit codes to `seg_display`.
- dp_out  out  4  to `seg_display` dp_in.
- blank  out  1  1 = display must be dark (alert blink-off phase).
- page  out  2  currently shown source: 0 = page 0, 1 = page 1, 2 = alert.
- alert_done  out  1  one-cycle pulse when an alert ends, by timeout or dismissal.

Behaviour:
- Registered outputs:
  - All outputs are registered.
  - Outputs in cycle n+1 reflect the state and source inputs sampled in cycle n.
  - Page sources are live: a source change appears one cycle later.
- Reset (async, rst_n=0):
  - State enters SHOW0 with all counters 0.
  - hex0..hex3=0, dp_out=0, blank=0, page=0, alert_done=0.
  - Latched alert data and return page are cleared to 0.
  - Reset mid-alert abandons the alert with no alert_done pulse.
- States: SHOW0, SHOW1, ALERT.
- SHOWx:
  - If rotate_en=1: dwell_cnt increments each cycle. At dwell_cnt==DWELL-1, switch to the other page and clear dwell_cnt.
  - If rotate_en=0: dwell_cnt is held at 0.
  - next_btn=1: switch to the other page immediately and clear dwell_cnt.
  - alert_req=1:
    - latch alert_data/alert_dp;
    - save the current page as the return page;
    - go to ALERT;
    - clear alert_cnt and dwell_cnt.
  - Priority in one cycle: alert_req > next_btn > dwell expiry. Dwell expiry coinciding with next_btn gives a single page advance, not two.
- ALERT:
  - alert_cnt increments each cycle.
  - blank = 1 during odd-numbered BLINK-length windows, i.e. when (alert_cnt / BLINK) is odd. blank is 0 during the first BLINK cycles.
  - hex/dp show the latched alert value; page=2.
  - Exit at alert_cnt==ALERT_HOLD-1, or on next_btn=1:
    - return to the saved page with dwell_cnt=0 and blank=0;
    - pulse alert_done for one cycle, aligned with the first output cycle of the returned page.
  - alert_req during ALERT re-latches the new data, restarts alert_cnt at 0 and keeps the original return page.
  - alert_req and next_btn in the same cycle: alert_req wins (retrigger, no dismissal, no alert_done).
  - alert_req in the same cycle as the timeout: retrigger wins, no alert_done.
  - rotate_en is ignored in ALERT; dwell_cnt is frozen at 0.
- blank is 0 in all states other than ALERT.
- No arithmetic beyond counter increments. Counters never wrap because they are cleared at their terminal counts.

Test Plan (overrides: DWELL=8, ALERT_HOLD=12, BLINK=3):
- Reset/hold: rst_n=0 for 20 cycles, src0=16'h2022, src1=16'h0118 -> all outputs 0 during reset. First clock edge after release -> hex3..hex0 = 2,0,2,2; page=0.
- Rotation: rotate_en=1 -> page toggles 0→1→0 every 8 cycles; hex shows 0118 with src1_dp=4'b1000 on page 1. Set rotate_en=0 mid-dwell -> page is frozen.
- Button: next_btn pulse -> page flips on the next output cycle and dwell restarts. next_btn in the same cycle as dwell expiry -> exactly one flip.
- Alert timeout: on page 1, alert_req with alert_data=16'hA1E7 -> page=2 next cycle.
  - blank pattern is 0,0,0,1,1,1,0,0,0,1,1,1 over the 12-cycle hold.
  - Then page=1, blank=0, and a one-cycle alert_done pulse.
- Retrigger/dismiss:
  - alert_req at alert_cnt=5 with new data -> new data shown, 12 more cycles, return page unchanged.
  - next_btn mid-alert -> immediate return plus alert_done.
  - alert_req+next_btn together -> retrigger only.
- Reset mid-alert: drop rst_n at alert_cnt=4 -> page=0, blank=0, no alert_done after release.
